// File: rtl/pfb_axis_sample_source.sv
// pfb_axis_sample_source
// AXI4-Stream ramp generator for the PFB input lanes (I/Q of channels 0-3).
// Each lane streams an independent, lane-tagged sample index framed by TLAST
// and honours its own TREADY. A watchdog flags sustained lack of progress.
module pfb_axis_sample_source #(
  parameter int LANES       = 8,
  parameter int DATA_W      = 16,
  parameter int FRAME_LEN   = 2048,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    start,
  input  logic [15:0]             num_frames,
  output logic                    busy,
  output logic                    done,
  output logic                    stall,
  output logic [LANES-1:0]        stall_lanes,
  output logic [LANES*DATA_W-1:0] din_tdata,
  output logic [LANES-1:0]        din_tvalid,
  input  logic [LANES-1:0]        din_tready,
  output logic [LANES-1:0]        din_tlast
);

  localparam int FL_LOG = $clog2(FRAME_LEN);
  localparam int WD_W   = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [15:0]       frames;
  logic [31:0]       idx [LANES];
  logic [LANES-1:0]  valid;
  logic [WD_W-1:0]   wd_cnt;

  logic [31:0]       total_len;
  logic [LANES-1:0]  hs;
  logic [LANES-1:0]  last_hs;
  logic [LANES-1:0]  valid_next;

  // Samples per lane for the whole run; FRAME_LEN is a power of two.
  assign total_len = {16'd0, frames} << FL_LOG;

  // Per-lane handshake and completion detection for this cycle.
  always_comb begin
    hs      = valid & din_tready;
    last_hs = '0;
    for (int i = 0; i < LANES; i++) begin
      last_hs[i] = hs[i] && ((idx[i] + 32'd1) == total_len);
    end
    valid_next = valid & ~last_hs;
  end

  // Output formatting: data and last are forced to zero while a lane is idle,
  // and only change on a handshake because idx only changes then.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign din_tdata[g*DATA_W +: DATA_W] =
      valid[g] ? {3'(g), idx[g][DATA_W-4:0]} : '0;
    assign din_tlast[g] =
      valid[g] && (idx[g][FL_LOG-1:0] == FL_LOG'(FRAME_LEN - 1));
  end

  assign din_tvalid = valid;

  // Lane counters and valids: cleared on accepted start, advanced per handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid <= '0;
      for (int i = 0; i < LANES; i++) idx[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) idx[i] <= '0;
            valid <= (num_frames != 16'd0) ? '1 : '0;
          end
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            if (hs[i]) idx[i] <= idx[i] + 32'd1;
          end
          valid <= valid_next;
        end
        default: valid <= '0;
      endcase
    end
  end

  // Control FSM with registered busy/done and the no-progress watchdog.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      frames      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stall       <= 1'b0;
      stall_lanes <= '0;
      wd_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frames      <= num_frames;
            stall       <= 1'b0;
            stall_lanes <= '0;
            wd_cnt      <= '0;
            if (num_frames == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          // Any handshake is progress; otherwise count while something waits,
          // and hold at the limit so the lane snapshot is taken only once.
          if (|hs) begin
            wd_cnt <= '0;
          end else if ((|valid) && (wd_cnt != WD_W'(STALL_LIMIT))) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(STALL_LIMIT - 1)) begin
              stall       <= 1'b1;
              stall_lanes <= valid & ~din_tready;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pfb_axis_sample_source.sv
// tb_pfb_axis_sample_source
// Directed bench: a cycle table for the full-rate run, a lane scoreboard for
// random backpressure, and hand sequences for watchdog, zero-frame and reset.
module tb_pfb_axis_sample_source;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int FL    = 8;
  localparam int SL    = 16;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              start;
  logic [15:0]       num_frames;
  logic              busy;
  logic              done;
  logic              stall;
  logic [LANES-1:0]  stall_lanes;
  logic [LANES*DW-1:0] din_tdata;
  logic [LANES-1:0]  din_tvalid;
  logic [LANES-1:0]  din_tready;
  logic [LANES-1:0]  din_tlast;

  int vectors;
  int miscompares;

  pfb_axis_sample_source #(
    .LANES(LANES), .DATA_W(DW), .FRAME_LEN(FL), .STALL_LIMIT(SL)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .num_frames(num_frames),
    .busy(busy), .done(done), .stall(stall), .stall_lanes(stall_lanes),
    .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tready(din_tready),
    .din_tlast(din_tlast)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [7:0]  rdy;
    logic [7:0]  vld;
    logic [7:0]  last;
    logic [15:0] d0;
    logic [15:0] d3;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [15:0] lane_d(input int i);
    return din_tdata[i*DW +: DW];
  endfunction

  function automatic logic [31:0] all_out();
    return {31'd0, (busy | done | stall | (|stall_lanes) | (|din_tvalid) |
                    (|din_tlast) | (|din_tdata))};
  endfunction

  task automatic do_start(input logic [15:0] nf, input logic [7:0] rdy);
    num_frames = nf;
    din_tready = rdy;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_idx [LANES];
    logic [7:0] rdy;
    logic [2:0] tag;
    bit all_fin;
    bit finished;

    vectors     = 0;
    miscompares = 0;

    // Full-rate run: FRAME_LEN=8, two frames, all lanes ready.
    tbl[0]  = '{8'hFF, 8'hFF, 8'h00, 16'h0000, 16'h6000, 1'b1, 1'b0};
    tbl[1]  = '{8'hFF, 8'hFF, 8'h00, 16'h0001, 16'h6001, 1'b1, 1'b0};
    tbl[2]  = '{8'hFF, 8'hFF, 8'h00, 16'h0002, 16'h6002, 1'b1, 1'b0};
    tbl[3]  = '{8'hFF, 8'hFF, 8'h00, 16'h0003, 16'h6003, 1'b1, 1'b0};
    tbl[4]  = '{8'hFF, 8'hFF, 8'h00, 16'h0004, 16'h6004, 1'b1, 1'b0};
    tbl[5]  = '{8'hFF, 8'hFF, 8'h00, 16'h0005, 16'h6005, 1'b1, 1'b0};
    tbl[6]  = '{8'hFF, 8'hFF, 8'h00, 16'h0006, 16'h6006, 1'b1, 1'b0};
    tbl[7]  = '{8'hFF, 8'hFF, 8'hFF, 16'h0007, 16'h6007, 1'b1, 1'b0};
    tbl[8]  = '{8'hFF, 8'hFF, 8'h00, 16'h0008, 16'h6008, 1'b1, 1'b0};
    tbl[9]  = '{8'hFF, 8'hFF, 8'h00, 16'h0009, 16'h6009, 1'b1, 1'b0};
    tbl[10] = '{8'hFF, 8'hFF, 8'h00, 16'h000A, 16'h600A, 1'b1, 1'b0};
    tbl[11] = '{8'hFF, 8'hFF, 8'h00, 16'h000B, 16'h600B, 1'b1, 1'b0};
    tbl[12] = '{8'hFF, 8'hFF, 8'h00, 16'h000C, 16'h600C, 1'b1, 1'b0};
    tbl[13] = '{8'hFF, 8'hFF, 8'h00, 16'h000D, 16'h600D, 1'b1, 1'b0};
    tbl[14] = '{8'hFF, 8'hFF, 8'h00, 16'h000E, 16'h600E, 1'b1, 1'b0};
    tbl[15] = '{8'hFF, 8'hFF, 8'hFF, 16'h000F, 16'h600F, 1'b1, 1'b0};
    tbl[16] = '{8'hFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[17] = '{8'hFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};

    ap_rst_n   = 1'b0;
    start      = 1'b0;
    num_frames = 16'd0;
    din_tready = 8'h00;

    // Reset held, then idle with no start.
    repeat (3) step();
    chk("reset_outputs", all_out(), 32'd0);
    ap_rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("idle_outputs", all_out(), 32'd0);
    end

    // Table-driven full-rate run.
    do_start(16'd2, 8'hFF);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("tbl%0d_vld", k), din_tvalid, tbl[k].vld);
      chk($sformatf("tbl%0d_last", k), din_tlast, tbl[k].last);
      chk($sformatf("tbl%0d_d0", k), lane_d(0), tbl[k].d0);
      chk($sformatf("tbl%0d_d3", k), lane_d(3), tbl[k].d3);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("tbl%0d_done", k), done, tbl[k].done);
      din_tready = tbl[k].rdy;
      step();
    end

    // Random per-lane backpressure against a per-lane index scoreboard.
    for (int l = 0; l < LANES; l++) exp_idx[l] = 0;
    finished = 1'b0;
    do_start(16'd2, 8'h00);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      all_fin = 1'b1;
      for (int l = 0; l < LANES; l++) if (exp_idx[l] != 16) all_fin = 1'b0;
      if (all_fin) begin
        chk("rand_done", done, 1'b1);
        chk("rand_busy", busy, 1'b0);
        finished = 1'b1;
        break;
      end
      chk("rand_done_early", done, 1'b0);
      rdy = 8'($urandom);
      din_tready = rdy;
      for (int l = 0; l < LANES; l++) begin
        if (exp_idx[l] < 16) begin
          tag = 3'(l);
          chk($sformatf("rand_vld%0d", l), din_tvalid[l], 1'b1);
          chk($sformatf("rand_data%0d", l), lane_d(l), {tag, 13'(exp_idx[l])});
          chk($sformatf("rand_last%0d", l), din_tlast[l], (exp_idx[l] % FL) == FL - 1);
          if (rdy[l]) exp_idx[l]++;
        end else begin
          chk($sformatf("rand_vld_off%0d", l), din_tvalid[l], 1'b0);
        end
      end
      step();
    end
    if (!finished) chk("rand_timeout", 32'd0, 32'd1);
    step();

    // Watchdog: three samples, then total backpressure.
    do_start(16'd2, 8'hFF);
    repeat (3) step();
    din_tready = 8'h00;
    for (int j = 1; j <= SL; j++) begin
      if (j == 8) begin
        num_frames = 16'd5;
        start      = 1'b1;
      end
      step();
      start = 1'b0;
      if (j < SL) chk($sformatf("wd_stall_pre%0d", j), stall, 1'b0);
    end
    chk("wd_stall_set", stall, 1'b1);
    chk("wd_stall_lanes", stall_lanes, 8'hFF);
    chk("wd_busy", busy, 1'b1);
    chk("wd_data_stable", lane_d(3), 16'h6003);
    repeat (3) step();
    chk("wd_stall_sticky", stall, 1'b1);
    din_tready = 8'hFF;
    for (int j = 1; j <= 13; j++) begin
      step();
      if (j == 12) chk("wd_done_early", done, 1'b0);
    end
    chk("wd_done", done, 1'b1);
    chk("wd_stall_after_done", stall, 1'b1);
    step();
    do_start(16'd1, 8'hFF);
    chk("wd_restart_stall", stall, 1'b0);
    chk("wd_restart_lanes", stall_lanes, 8'h00);
    chk("wd_restart_busy", busy, 1'b1);
    repeat (8) step();
    chk("wd_restart_done", done, 1'b1);
    step();

    // Partial watchdog: only lane 5 blocked.
    do_start(16'd2, 8'hDF);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 16) begin
        chk("pw_valid_lane5", din_tvalid, 8'h20);
        chk("pw_stall_while_others", stall, 1'b0);
        chk("pw_lane5_data", lane_d(5), 16'hA000);
      end
      if (k == 31) chk("pw_stall_pre", stall, 1'b0);
    end
    chk("pw_stall_set", stall, 1'b1);
    chk("pw_stall_lanes", stall_lanes, 8'h20);
    din_tready = 8'hFF;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 15) chk("pw_done_early", done, 1'b0);
    end
    chk("pw_done", done, 1'b1);
    step();

    // Zero frames: done immediately, nothing streamed.
    do_start(16'd0, 8'hFF);
    chk("nf0_done", done, 1'b1);
    chk("nf0_busy", busy, 1'b0);
    chk("nf0_vld", din_tvalid, 8'h00);
    step();
    chk("nf0_done_pulse", done, 1'b0);
    chk("nf0_vld_after", din_tvalid, 8'h00);
    step();

    // Reset in the middle of a run.
    do_start(16'd2, 8'hFF);
    repeat (5) step();
    chk("mr_running", lane_d(3), 16'h6005);
    #1 ap_rst_n = 1'b0;
    #1 chk("mr_async_clear", all_out(), 32'd0);
    repeat (2) step();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("mr_no_done", {31'd0, done | busy}, 32'd0);
    end
    do_start(16'd1, 8'hFF);
    chk("mr_restart_vld", din_tvalid, 8'hFF);
    chk("mr_restart_d0", lane_d(0), 16'h0000);
    chk("mr_restart_d3", lane_d(3), 16'h6000);
    repeat (8) step();
    chk("mr_restart_done", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
